// File: rtl/gumnut_dp_pkg.sv
// Shared definitions for the Gumnut register/ALU datapath.
//   alu_fn_t : ALU/shifter function codes carried on fn_c
//   regmux_t : write-back source select carried on RegMux_c
//   state_t  : execution FSM states
//   IR_*     : bit positions of the fields inside the 18-bit instruction word
package gumnut_dp_pkg;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_ADDC = 4'd1,
        FN_SUB  = 4'd2,
        FN_SUBC = 4'd3,
        FN_AND  = 4'd4,
        FN_OR   = 4'd5,
        FN_XOR  = 4'd6,
        FN_MASK = 4'd7,
        FN_SHL  = 4'd8,
        FN_SHR  = 4'd9,
        FN_ROL  = 4'd10,
        FN_ROR  = 4'd11,
        FN_NOP0 = 4'd12,
        FN_NOP1 = 4'd13,
        FN_NOP2 = 4'd14,
        FN_NOP3 = 4'd15
    } alu_fn_t;

    typedef enum logic [1:0] {
        MUX_ALU  = 2'd0,
        MUX_DATA = 2'd1,
        MUX_PORT = 2'd2,
        MUX_ALU2 = 2'd3
    } regmux_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int unsigned IR_W        = 18;
    localparam int unsigned IR_OP_LSB   = 11;  // op_e   = IR[17:11]
    localparam int unsigned IR_RD_LSB   = 11;  // rd     = IR[13:11]
    localparam int unsigned IR_RS_LSB   = 8;   // rs     = IR[10:8]
    localparam int unsigned IR_RS2_LSB  = 5;   // rs2    = IR[7:5]
    localparam int unsigned IR_CNT_LSB  = 5;   // count  = IR[7:5]
    localparam int unsigned IR_IMM_LSB  = 0;   // imm/disp/offset = IR[7:0]
    localparam int unsigned IR_FUNC_LSB = 0;   // func   = IR[2:0]
    localparam int unsigned IR_ADDR_LSB = 0;   // addr   = IR[11:0]

    function automatic logic is_shift(input alu_fn_t fn);
        return (fn >= FN_SHL) && (fn <= FN_ROR);
    endfunction

    function automatic logic is_alu(input alu_fn_t fn);
        return fn <= FN_ROR;
    endfunction

endpackage

// File: rtl/gumnut_regfile.sv
// NREG x DW register file, two combinational read ports, one synchronous
// write port. r0 always reads zero; writes to r0 or to an address >= NREG
// are dropped.
//   clk_i, rst_i       clock, synchronous active-high reset (clears all)
//   we, waddr, wdata   write port
//   raddr_a/rdata_a    read port A
//   raddr_b/rdata_b    read port B
module gumnut_regfile #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we,
    input  logic [2:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [2:0]    raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [2:0]    raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] regs [NREG];

    // Decoded by comparison so an out-of-range address simply matches nothing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (waddr == 3'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (raddr_a == 3'(i)) rdata_a = regs[i];
            if (raddr_b == 3'(i)) rdata_b = regs[i];
        end
    end

endmodule

// File: rtl/gumnut_exec_unit.sv
// Gumnut register/ALU execution unit: instruction latch, register file,
// ALU, shifter and registered carry/zero flags. One op per start_c pulse.
// Build option: SHIFT_BARREL_EN selects a single-cycle barrel shifter
// (shifts go through EXEC); otherwise shifts iterate one bit per cycle.
//   clk_i/rst_i/ClkEn_e      clock, sync reset, clock enable
//   inst_dat_i/inst_ack_i    instruction word and its load strobe
//   start_c/fn_c/op2_c       op start, function, operand-2 select
//   RegMux_c/RegWrt_c        write-back source and enable
//   data_dat_i/port_dat_i    memory / I/O read data for write-back
//   busy_o/done_o/res_o      status and last result
//   rs_o                     combinational rs read value
//   carry_e/zero_e           flags
//   op_e/func_e/addr_e/disp_e/offset_e  IR fields
module gumnut_exec_unit
    import gumnut_dp_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ClkEn_e,
    input  logic [17:0]   inst_dat_i,
    input  logic          inst_ack_i,
    input  logic          start_c,
    input  logic [3:0]    fn_c,
    input  logic          op2_c,
    input  logic [1:0]    RegMux_c,
    input  logic          RegWrt_c,
    input  logic [DW-1:0] data_dat_i,
    input  logic [DW-1:0] port_dat_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] res_o,
    output logic [DW-1:0] rs_o,
    output logic          carry_e,
    output logic          zero_e,
    output logic [6:0]    op_e,
    output logic [2:0]    func_e,
    output logic [11:0]   addr_e,
    output logic [7:0]    disp_e,
    output logic [7:0]    offset_e
);

    logic [IR_W-1:0] ir_q;
    state_t          state_q;
    logic [DW-1:0]   a_q, b_q, sh_q, res_q;
    alu_fn_t         fn_q;
    regmux_t         mux_q;
    logic            wrt_q, sh_c_q, carry_q, zero_q, done_q;
    logic [2:0]      rd_q, cnt_q;

    logic [DW-1:0]   rs_val, rs2_val, imm_ext;
    logic [DW-1:0]   exec_res, fin_res, wb_val;
    logic            exec_c, fin_c, finishing, last_step, upd_flags;
    logic [DW:0]     sum, sh_step;

    gumnut_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we      (finishing && wrt_q),
        .waddr   (rd_q),
        .wdata   (wb_val),
        .raddr_a (ir_q[IR_RS_LSB +: 3]),
        .rdata_a (rs_val),
        .raddr_b (ir_q[IR_RS2_LSB +: 3]),
        .rdata_b (rs2_val)
    );

    assign imm_ext = DW'(ir_q[IR_IMM_LSB +: 8]);

    // Single-bit shift step; returns {carry, value}. Rotates keep carry.
    function automatic logic [DW:0] shift1(input alu_fn_t f, input logic [DW-1:0] v,
                                           input logic c);
        case (f)
            FN_SHL:  return {v[DW-1], v[DW-2:0], 1'b0};
            FN_SHR:  return {v[0], 1'b0, v[DW-1:1]};
            FN_ROL:  return {c, v[DW-2:0], v[DW-1]};
            FN_ROR:  return {c, v[0], v[DW-1:1]};
            default: return {c, v};
        endcase
    endfunction

    always_comb begin
        sum      = '0;
        exec_res = a_q;
        exec_c   = carry_q;
        case (fn_q)
            FN_ADD:  sum = {1'b0, a_q} + {1'b0, b_q};
            FN_ADDC: sum = {1'b0, a_q} + {1'b0, b_q} + (DW+1)'(carry_q);
            FN_SUB:  sum = {1'b0, a_q} - {1'b0, b_q};
            FN_SUBC: sum = {1'b0, a_q} - {1'b0, b_q} - (DW+1)'(carry_q);
            default: sum = '0;
        endcase
        case (fn_q)
            FN_ADD, FN_ADDC, FN_SUB, FN_SUBC: begin
                exec_res = sum[DW-1:0];
                exec_c   = sum[DW];
            end
            FN_AND:  begin exec_res = a_q & b_q;  exec_c = 1'b0; end
            FN_OR:   begin exec_res = a_q | b_q;  exec_c = 1'b0; end
            FN_XOR:  begin exec_res = a_q ^ b_q;  exec_c = 1'b0; end
            FN_MASK: begin exec_res = a_q & ~b_q; exec_c = 1'b0; end
`ifdef SHIFT_BARREL_EN
            FN_SHL, FN_SHR, FN_ROL, FN_ROR: begin
                // Unrolled chain of single-bit steps, so results and carry
                // match the iterative shifter bit for bit.
                for (int unsigned i = 0; i < 7; i++) begin
                    if (3'(i) < cnt_q) begin
                        {exec_c, exec_res} = shift1(fn_q, exec_res, exec_c);
                    end
                end
            end
`endif
            default: begin
                exec_res = a_q;
                exec_c   = carry_q;
            end
        endcase
    end

    // Iterative shifter: count 0 finishes in one cycle with the operand unchanged.
    assign sh_step   = shift1(fn_q, sh_q, sh_c_q);
    assign last_step = (cnt_q <= 3'd1);

    assign finishing = ClkEn_e && ((state_q == EXEC) || ((state_q == SHIFT) && last_step));

    always_comb begin
        fin_res = exec_res;
        fin_c   = exec_c;
        if (state_q == SHIFT) begin
            if (cnt_q == 3'd0) begin
                fin_res = sh_q;
                fin_c   = sh_c_q;
            end else begin
                fin_res = sh_step[DW-1:0];
                fin_c   = sh_step[DW];
            end
        end
    end

    assign upd_flags = is_alu(fn_q) && ((mux_q == MUX_ALU) || (mux_q == MUX_ALU2));

    always_comb begin
        case (mux_q)
            MUX_DATA: wb_val = data_dat_i;
            MUX_PORT: wb_val = port_dat_i;
            default:  wb_val = fin_res;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_q    <= '0;
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sh_c_q  <= 1'b0;
            fn_q    <= FN_ADD;
            mux_q   <= MUX_ALU;
            wrt_q   <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ClkEn_e) begin
            if (inst_ack_i) begin
                ir_q <= inst_dat_i;
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        a_q    <= rs_val;
                        b_q    <= op2_c ? imm_ext : rs2_val;
                        sh_q   <= rs_val;
                        sh_c_q <= carry_q;
                        fn_q   <= alu_fn_t'(fn_c);
                        mux_q  <= regmux_t'(RegMux_c);
                        wrt_q  <= RegWrt_c;
                        rd_q   <= ir_q[IR_RD_LSB +: 3];
                        cnt_q  <= ir_q[IR_CNT_LSB +: 3];
`ifdef SHIFT_BARREL_EN
                        state_q <= EXEC;
`else
                        state_q <= is_shift(alu_fn_t'(fn_c)) ? SHIFT : EXEC;
`endif
                    end
                end
                EXEC, SHIFT: begin
                    if (finishing) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        if (is_alu(fn_q)) begin
                            res_q <= fin_res;
                        end
                        if (upd_flags) begin
                            carry_q <= fin_c;
                            zero_q  <= (fin_res == '0);
                        end
                    end else begin
                        sh_q   <= sh_step[DW-1:0];
                        sh_c_q <= sh_step[DW];
                        cnt_q  <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign res_o    = res_q;
    assign rs_o     = rs_val;
    assign carry_e  = carry_q;
    assign zero_e   = zero_q;
    assign op_e     = ir_q[IR_OP_LSB +: 7];
    assign func_e   = ir_q[IR_FUNC_LSB +: 3];
    assign addr_e   = ir_q[IR_ADDR_LSB +: 12];
    assign disp_e   = ir_q[IR_IMM_LSB +: 8];
    assign offset_e = ir_q[IR_IMM_LSB +: 8];

endmodule

// File: tb/tb_gumnut_exec_unit.sv
module tb_gumnut_exec_unit;

    localparam int DW   = 8;
    localparam int NREG = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, ClkEn_e, inst_ack_i, start_c, op2_c, RegWrt_c;
    logic [17:0]   inst_dat_i;
    logic [3:0]    fn_c;
    logic [1:0]    RegMux_c;
    logic [DW-1:0] data_dat_i, port_dat_i;
    logic          busy_o, done_o, carry_e, zero_e;
    logic [DW-1:0] res_o, rs_o;
    logic [6:0]    op_e;
    logic [2:0]    func_e;
    logic [11:0]   addr_e;
    logic [7:0]    disp_e, offset_e;

    gumnut_exec_unit #(.DW(DW), .NREG(NREG)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ClkEn_e    (ClkEn_e),
        .inst_dat_i (inst_dat_i),
        .inst_ack_i (inst_ack_i),
        .start_c    (start_c),
        .fn_c       (fn_c),
        .op2_c      (op2_c),
        .RegMux_c   (RegMux_c),
        .RegWrt_c   (RegWrt_c),
        .data_dat_i (data_dat_i),
        .port_dat_i (port_dat_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .res_o      (res_o),
        .rs_o       (rs_o),
        .carry_e    (carry_e),
        .zero_e     (zero_e),
        .op_e       (op_e),
        .func_e     (func_e),
        .addr_e     (addr_e),
        .disp_e     (disp_e),
        .offset_e   (offset_e)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       sbq[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mregs[8];
    logic       mc, mz;
    logic [7:0] mres;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference ALU for DW=8, written from the ISA description.
    task automatic ref_alu(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] n, input logic cin,
                           output logic [7:0] r, output logic c);
        int          s;
        logic [15:0] t;
        r = a;
        c = cin;
        case (fn)
            4'd0: begin s = int'(a) + int'(b);            r = s[7:0]; c = s[8]; end
            4'd1: begin s = int'(a) + int'(b) + int'(cin); r = s[7:0]; c = s[8]; end
            4'd2: begin s = int'(a) - int'(b);            r = s[7:0]; c = (s < 0); end
            4'd3: begin s = int'(a) - int'(b) - int'(cin); r = s[7:0]; c = (s < 0); end
            4'd4: begin r = a & b;  c = 1'b0; end
            4'd5: begin r = a | b;  c = 1'b0; end
            4'd6: begin r = a ^ b;  c = 1'b0; end
            4'd7: begin r = a & ~b; c = 1'b0; end
            4'd8: if (n != 0) begin t = {8'h00, a} << n; r = t[7:0];  c = t[8]; end
            4'd9: if (n != 0) begin t = {a, 8'h00} >> n; r = t[15:8]; c = t[7]; end
            4'd10: begin t = {a, a} << n; r = t[15:8]; end
            4'd11: begin t = {a, a} >> n; r = t[7:0]; end
            default: begin r = a; c = cin; end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] fn, input logic op2,
                          input logic [1:0] mux, input logic wrt, input logic [2:0] rd,
                          input logic [2:0] rs, input logic [7:0] low8,
                          input logic [7:0] dat, input int freeze);
        logic [7:0] a, b, r, wbv, old_res;
        logic [2:0] n;
        logic       c, isalu, upd;
        exp_t       e;
        int         nb, expb;

        inst_dat_i = {4'b0000, rd, rs, low8};
        inst_ack_i = 1'b1;
        tick();
        inst_ack_i = 1'b0;

        n     = low8[7:5];
        a     = mregs[rs];
        b     = op2 ? low8 : mregs[n];
        ref_alu(fn, a, b, n, mc, r, c);
        isalu = (fn < 4'd12);
        upd   = isalu && (mux == 2'd0 || mux == 2'd3);
        old_res = mres;
        if (isalu) mres = r;
        if (upd) begin
            mc = c;
            mz = (r == 8'h00);
        end
        e.res = mres;
        e.c   = mc;
        e.z   = mz;
        sbq.push_back(e);
        case (mux)
            2'd1:    wbv = dat;
            2'd2:    wbv = ~dat;
            default: wbv = isalu ? r : a;
        endcase
        if (wrt && rd != 3'd0 && int'(rd) < NREG) mregs[rd] = wbv;
        expb = 1;
`ifndef SHIFT_BARREL_EN
        if (fn >= 4'd8 && fn <= 4'd11) expb = (n == 3'd0) ? 1 : int'(n);
`endif

        data_dat_i = dat;
        port_dat_i = ~dat;
        fn_c       = fn;
        op2_c      = op2;
        RegMux_c   = mux;
        RegWrt_c   = wrt;
        start_c    = 1'b1;
        tick();
        start_c    = 1'b0;

        nb = 0;
        while (busy_o === 1'b1 && nb < 40) begin
            nb++;
            if (freeze > 0 && nb == 1) begin
                ClkEn_e = 1'b0;
                repeat (freeze) begin
                    tick();
                    check({tag, " frz_busy"}, 32'(busy_o), 32'd1);
                    check({tag, " frz_res"}, 32'(res_o), 32'(old_res));
                end
                ClkEn_e = 1'b1;
            end
            tick();
        end
        check({tag, " busy_cycles"}, 32'(nb), 32'(expb));
        check({tag, " done"}, 32'(done_o), 32'd1);
        if (done_o === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, " res"}, 32'(res_o), 32'(e.res));
            check({tag, " carry"}, 32'(carry_e), 32'(e.c));
            check({tag, " zero"}, 32'(zero_e), 32'(e.z));
        end
        tick();
        check({tag, " done_pulse"}, 32'(done_o), 32'd0);
    endtask

    task automatic read_reg(input string tag, input logic [2:0] idx);
        inst_dat_i = {4'b0000, 3'd0, idx, 8'h00};
        inst_ack_i = 1'b1;
        tick();
        inst_ack_i = 1'b0;
        check(tag, 32'(rs_o), 32'(mregs[idx]));
    endtask

    initial begin
        logic [17:0] iw;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mc = 1'b0; mz = 1'b0; mres = 8'h00;
        rst_i = 1'b1; ClkEn_e = 1'b1; inst_ack_i = 1'b0; start_c = 1'b0;
        inst_dat_i = '0; fn_c = '0; op2_c = 1'b0; RegMux_c = '0; RegWrt_c = 1'b0;
        data_dat_i = '0; port_dat_i = '0;
        tick();
        tick();
        rst_i = 1'b0;

        check("rst_res", 32'(res_o), 32'd0);
        check("rst_carry", 32'(carry_e), 32'd0);
        check("rst_zero", 32'(zero_e), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_addr", 32'(addr_e), 32'd0);

        iw = 18'h2D5A7;
        inst_dat_i = iw; inst_ack_i = 1'b1;
        tick();
        inst_ack_i = 1'b0;
        check("ir_op", 32'(op_e), 32'(iw[17:11]));
        check("ir_addr", 32'(addr_e), 32'(iw[11:0]));
        check("ir_func", 32'(func_e), 32'(iw[2:0]));
        check("ir_disp", 32'(disp_e), 32'(iw[7:0]));

        // start_c is ignored while the clock enable is low
        ClkEn_e = 1'b0; start_c = 1'b1; fn_c = 4'd0;
        tick();
        start_c = 1'b0; ClkEn_e = 1'b1;
        check("clken_start_ignored", 32'(busy_o), 32'd0);

        run_op("ld_r1", 4'd12, 1'b0, 2'd1, 1'b1, 3'd1, 3'd0, 8'h00, 8'hFF, 0);
        run_op("ld_r2", 4'd12, 1'b0, 2'd1, 1'b1, 3'd2, 3'd0, 8'h00, 8'h01, 0);
        run_op("t1_add", 4'd0, 1'b0, 2'd0, 1'b1, 3'd3, 3'd1, 8'h40, 8'h00, 0);
        read_reg("t1_r3", 3'd3);

        run_op("ld_r1b", 4'd12, 1'b0, 2'd1, 1'b1, 3'd1, 3'd0, 8'h00, 8'h05, 0);
        run_op("t2_subc", 4'd3, 1'b1, 2'd0, 1'b1, 3'd2, 3'd1, 8'h05, 8'h00, 0);
        read_reg("t2_r2", 3'd2);

        run_op("ld_r1c", 4'd12, 1'b0, 2'd1, 1'b1, 3'd1, 3'd0, 8'h00, 8'h81, 0);
        run_op("t3_shl3", 4'd8, 1'b0, 2'd0, 1'b1, 3'd3, 3'd1, 8'h60, 8'h00, 0);
        read_reg("t3_r3", 3'd3);
        run_op("shr1", 4'd9, 1'b0, 2'd0, 1'b0, 3'd0, 3'd1, 8'h20, 8'h00, 0);
        run_op("rol2", 4'd10, 1'b0, 2'd0, 1'b0, 3'd0, 3'd1, 8'h40, 8'h00, 0);
        run_op("ror1", 4'd11, 1'b0, 2'd0, 1'b0, 3'd0, 3'd1, 8'h20, 8'h00, 0);
        run_op("shl0", 4'd8, 1'b0, 2'd0, 1'b0, 3'd0, 3'd1, 8'h00, 8'h00, 0);
        run_op("and", 4'd4, 1'b1, 2'd0, 1'b0, 3'd0, 3'd1, 8'h0F, 8'h00, 0);
        run_op("or", 4'd5, 1'b1, 2'd3, 1'b0, 3'd0, 3'd1, 8'h70, 8'h00, 0);
        run_op("xor", 4'd6, 1'b1, 2'd0, 1'b0, 3'd0, 3'd1, 8'h81, 8'h00, 0);
        run_op("mask", 4'd7, 1'b1, 2'd0, 1'b0, 3'd0, 3'd1, 8'h80, 8'h00, 0);
        run_op("addc0", 4'd1, 1'b1, 2'd0, 1'b0, 3'd0, 3'd1, 8'h7F, 8'h00, 0);
        run_op("addc1", 4'd1, 1'b1, 2'd0, 1'b1, 3'd2, 3'd1, 8'h00, 8'h00, 0);
        run_op("sub", 4'd2, 1'b1, 2'd0, 1'b0, 3'd0, 3'd1, 8'h90, 8'h00, 0);
        run_op("nop", 4'd13, 1'b0, 2'd0, 1'b0, 3'd0, 3'd1, 8'h00, 8'h00, 0);
        run_op("add_memwb", 4'd0, 1'b1, 2'd1, 1'b1, 3'd3, 3'd1, 8'h01, 8'h3C, 0);
        run_op("add_portwb", 4'd0, 1'b1, 2'd2, 1'b1, 3'd2, 3'd1, 8'h7F, 8'h3C, 0);
        read_reg("mem_r3", 3'd3);
        read_reg("port_r2", 3'd2);

        run_op("t4_wr_r0", 4'd12, 1'b0, 2'd1, 1'b1, 3'd0, 3'd0, 8'h00, 8'hAA, 0);
        run_op("t4_wr_r5", 4'd12, 1'b0, 2'd1, 1'b1, 3'd5, 3'd0, 8'h00, 8'h55, 0);
        read_reg("t4_r0", 3'd0);
        read_reg("t4_r1", 3'd1);
        read_reg("t4_r2", 3'd2);
        read_reg("t4_r3", 3'd3);
        read_reg("t4_r5", 3'd5);

        run_op("t5_freeze", 4'd8, 1'b0, 2'd0, 1'b1, 3'd2, 3'd1, 8'h60, 8'h00, 5);
        read_reg("t5_r2", 3'd2);

        // Reset in the middle of a shift: aborts with no write-back.
        inst_dat_i = {4'b0000, 3'd3, 3'd1, 8'h80};
        inst_ack_i = 1'b1;
        tick();
        inst_ack_i = 1'b0;
        fn_c = 4'd8; op2_c = 1'b0; RegMux_c = 2'd0; RegWrt_c = 1'b1; start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("t6_busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_carry", 32'(carry_e), 32'd0);
        check("t6_zero", 32'(zero_e), 32'd0);
        check("t6_res", 32'(res_o), 32'd0);
        tick();
        check("t6_no_done", 32'(done_o), 32'd0);
        read_reg("t6_r3", 3'd3);
        read_reg("t6_r1", 3'd1);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
